zeus_multicycle_control: RTL



---
 rtl/zeus_pkg.sv | 48 ++++
 rtl/zeus_mem_wait_timer.sv | 34 +++
 rtl/zeus_multicycle_control.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/zeus_pkg.sv
// Shared encodings for the Zeus multi-cycle sequencer: states, opcodes, ALU/PC codes, faults.
package zeus_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned WAIT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_HALT      = 4'd13
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/zeus_mem_wait_timer.sv
// Counts consecutive cycles a memory access is stalled; flags the cycle that exhausts LIMIT.
module zeus_mem_wait_timer
    import zeus_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic wait_en,
    output logic timeout_c
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Any cycle that is not a stall restarts the count, so each access starts at zero.
    always_comb begin
        count_d   = '0;
        timeout_c = 1'b0;
        if (wait_en) begin
            count_d   = count_q + WAIT_W'(1);
            timeout_c = (count_q == WAIT_W'(LIMIT - 1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/zeus_multicycle_control.sv
// Multi-cycle control sequencer for the Zeus datapath with memory ready handshake and retire counter.
module zeus_multicycle_control
    import zeus_pkg::*;
#(
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         op_code,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic               instr_done,
    output logic               halted,
    output logic [1:0]         fault,
    output logic [COUNT_W-1:0] instr_count
);

    state_t               state_q, state_d;
    logic [1:0]           fault_q, fault_d;
    logic [COUNT_W-1:0]   instr_count_q, instr_count_d;
    logic                 wait_en_c;
    logic                 timeout_c;
    state_t               retire_state_c;

    // Only the three memory-access states can stall on mem_ready.
    assign wait_en_c = ((state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                        (state_q == ST_MEM_WRITE)) && !mem_ready;

    zeus_mem_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .wait_en   (wait_en_c),
        .timeout_c (timeout_c)
    );

    assign retire_state_c = run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        halted        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM;
                case (op_code)
                    OP_RTYPE:      state_d = ST_R_EXEC;
                    OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
                    OP_BEQ:        state_d = ST_BRANCH;
                    OP_J:          state_d = ST_JUMP;
                    OP_ADDI:       state_d = ST_ADDI_EXEC;
                    default: begin
                        state_d = ST_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_code == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timeout_c) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state_c;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = retire_state_c;
                end else if (timeout_c) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state_c;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALU_OUT;
                instr_done    = 1'b1;
                state_d       = retire_state_c;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = retire_state_c;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state_c;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
                fault_d = FAULT_ILLEGAL;
            end
        endcase

        instr_count_d = instr_count_q + COUNT_W'(instr_done);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fault_q       <= FAULT_NONE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign fault       = fault_q;
    assign instr_count = instr_count_q;

endmodule
